// File: rtl/pix_cfg_pkg.sv
// rtl/pix_cfg_pkg.sv - shared state encoding, register indices and word size for the pixel config sequencer.
package pix_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SH_LO = 2'd1,
    SH_HI = 2'd2,
    LOAD  = 2'd3
  } cfg_state_e;

  localparam logic [2:0] IDX_FRAME = 3'b000;
  localparam logic [2:0] IDX_CFG   = 3'b001;
  localparam logic [2:0] IDX_RB    = 3'b110;
  localparam logic [2:0] IDX_PUSH  = 3'b111;

  localparam int CFG_BITS = 6;

endpackage

// File: rtl/pix_cfg_phase_timer.sv
// rtl/pix_cfg_phase_timer.sv - down-counter timing one shift half-period or the load pulse.
module pix_cfg_phase_timer #(
  parameter int W = 8
) (
  input  logic         spi_clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         run,
  output logic         expire
);

  logic [W-1:0] cnt;

  // cnt holds the cycles remaining after the current one; expire marks the last cycle of a phase.
  always_ff @(posedge spi_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (run && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = run && (cnt == '0);

endmodule

// File: rtl/pix_cfg_sequencer.sv
// rtl/pix_cfg_sequencer.sv - serialises double-column config words onto the pixel chain and strobes the latch.
// Optional readback accumulator (rb_word/rb_valid) is built when PIX_CFG_READBACK_EN is defined.
module pix_cfg_sequencer
  import pix_cfg_pkg::*;
#(
  parameter int NUM_DCOL = 64,
  parameter int HALF_PER = 2,
  parameter int LOAD_CYC = 4
) (
  input  logic       spi_clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] index,
  input  logic [7:0] data_in,
  input  logic       config_en,
  input  logic       chain_do,
  output logic       cfg_sdi,
  output logic       cfg_sclk,
  output logic       cfg_load,
  output logic       config_do,
  output logic       busy,
  output logic [7:0] col_cnt,
  output logic       frame_done,
`ifdef PIX_CFG_READBACK_EN
  output logic       overrun,
  output logic [5:0] rb_word,
  output logic       rb_valid
`else
  output logic       overrun
`endif
);

  localparam logic [7:0] NUM_DCOL8 = 8'(NUM_DCOL);
  localparam logic [7:0] HALF_PER8 = 8'(HALF_PER);
  localparam logic [7:0] LOAD_CYC8 = 8'(LOAD_CYC);

  cfg_state_e state;
  logic [5:0] sr;
  logic [2:0] bit_cnt;
  logic       hi_first;
  logic       commit_pend;

  logic       frame_wr, commit_wr, room, last_bit;
  logic       take_cfg, go_load;
  logic       tmr_load, tmr_expire;
  logic [7:0] tmr_val;
  logic       unused_bits;

  assign unused_bits = &{1'b0, data_in[7:6]};

  always_comb begin
    frame_wr  = wr_en && (index == IDX_FRAME) && data_in[0];
    commit_wr = wr_en && (index == IDX_PUSH);
    room      = col_cnt < NUM_DCOL8;
    last_bit  = bit_cnt == 3'(CFG_BITS - 1);
    // A frame start in IDLE takes the whole cycle; everything else on that cycle is ignored.
    take_cfg  = (state == IDLE) && !frame_wr && config_en && room;
    go_load   = (state == IDLE) && !frame_wr && !room && (commit_pend || commit_wr);
    tmr_load  = take_cfg || go_load ||
                (tmr_expire && (state == SH_LO || (state == SH_HI && !last_bit)));
    tmr_val   = go_load ? LOAD_CYC8 : HALF_PER8;
  end

  pix_cfg_phase_timer #(.W(8)) u_timer (
    .spi_clk  (spi_clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .run      (state != IDLE),
    .expire   (tmr_expire)
  );

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state       <= IDLE;
      sr          <= '0;
      bit_cnt     <= '0;
      hi_first    <= 1'b0;
      commit_pend <= 1'b0;
      cfg_sdi     <= 1'b0;
      cfg_sclk    <= 1'b0;
      cfg_load    <= 1'b0;
      config_do   <= 1'b0;
      busy        <= 1'b0;
      col_cnt     <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
`ifdef PIX_CFG_READBACK_EN
      rb_word     <= '0;
      rb_valid    <= 1'b0;
`endif
    end else begin
`ifdef PIX_CFG_READBACK_EN
      rb_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (frame_wr) begin
            col_cnt     <= '0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            commit_pend <= 1'b0;
          end else begin
            if (commit_pend) begin
              commit_pend <= 1'b0;
              if (room) overrun <= 1'b1;
            end
            if (config_en && !room) overrun <= 1'b1;
            if (commit_wr) begin
              if (take_cfg) commit_pend <= 1'b1;
              else if (room) overrun <= 1'b1;
            end
            if (take_cfg) begin
              sr      <= data_in[5:0];
              bit_cnt <= '0;
              cfg_sdi <= data_in[5];
              busy    <= 1'b1;
              state   <= SH_LO;
            end
            if (go_load) begin
              cfg_load <= 1'b1;
              busy     <= 1'b1;
              state    <= LOAD;
            end
          end
        end

        SH_LO: begin
          if (config_en || frame_wr) overrun <= 1'b1;
          if (commit_wr) commit_pend <= 1'b1;
          if (tmr_expire) begin
            cfg_sclk <= 1'b1;
            hi_first <= 1'b1;
            state    <= SH_HI;
          end
        end

        SH_HI: begin
          if (config_en || frame_wr) overrun <= 1'b1;
          if (commit_wr) commit_pend <= 1'b1;
          hi_first <= 1'b0;
          if (hi_first) begin
            config_do <= chain_do;
`ifdef PIX_CFG_READBACK_EN
            rb_word   <= {rb_word[4:0], chain_do};
`endif
          end
          if (tmr_expire) begin
            cfg_sclk <= 1'b0;
            bit_cnt  <= bit_cnt + 3'd1;
            if (last_bit) begin
              cfg_sdi <= 1'b0;
              busy    <= 1'b0;
              if (col_cnt != NUM_DCOL8) col_cnt <= col_cnt + 8'd1;
`ifdef PIX_CFG_READBACK_EN
              rb_valid <= 1'b1;
`endif
              state   <= IDLE;
            end else begin
              sr      <= {sr[4:0], 1'b0};
              cfg_sdi <= sr[4];
              state   <= SH_LO;
            end
          end
        end

        LOAD: begin
          if (config_en || frame_wr || commit_wr) overrun <= 1'b1;
          if (tmr_expire) begin
            cfg_load   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
`ifdef PIX_CFG_READBACK_EN
      if (wr_en && index == IDX_RB && data_in[0]) rb_word <= '0;
`endif
    end
  end

endmodule

// File: doc/pix_cfg_sequencer.md
Name: pix_cfg_sequencer

Overview:
Controller between the SPI slave interface and the pixel-matrix configuration shift chain. It takes each 6-bit double-column config word handed over on config_en and serialises it MSB-first onto the pixel chain with a generated shift clock. It counts double-columns per frame and fires the latch (load) strobe when a commit write to register 111 arrives. It returns the bit shifted out of the chain end for SPI readback and flags protocol violations.

Parameters:
NUM_DCOL, 64, double-columns per frame; legal range is 1..255.
HALF_PER, 2, spi_clk cycles per cfg_sclk phase (low and high); minimum 1.
LOAD_CYC, 4, width of the cfg_load pulse in spi_clk cycles; minimum 1.

Ports:
spi_clk  in  1  block clock; single clock domain.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  register write strobe from the SPI interface, one cycle wide.
index  in  3  register address qualifying wr_en.
data_in  in  8  register write data; bits [5:0] are the config word.
config_en  in  1  pulse: data_in[5:0] holds a double-column config word.
chain_do  in  1  serial output from the end of the pixel chain.
cfg_sdi  out  1  serial data into the pixel chain.
cfg_sclk  out  1  chain shift clock; the chain samples on the rising edge.
cfg_load  out  1  latch strobe for the pixel config registers.
config_do  out  1  last chain_do sample, returned to SPI sdo.
busy  out  1  high while shifting or loading.
col_cnt  out  8  double-columns shifted in the current frame.
frame_done  out  1  sticky; set after a completed load.
overrun  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, spi_clk; reset is synchronous and active-high, port rst.
- Reset values: all outputs 0; state IDLE; commit_pend 0.
- States: IDLE, SH_LO, SH_HI, LOAD.
- Frame start (wr_en, index==000, data_in[0]==1):
  - In IDLE: next cycle col_cnt=0, frame_done=0, overrun=0, commit_pend=0.
  - In any other state: ignored and overrun is set.
- config_en in IDLE with col_cnt<NUM_DCOL:
  - Latch data_in[5:0] into a shift register and clear the bit counter.
  - Next cycle: state SH_LO, busy=1.
- SH_LO:
  - cfg_sdi = current MSB; cfg_sclk=0; hold for HALF_PER cycles, then go to SH_HI.
- SH_HI:
  - cfg_sclk=1 for HALF_PER cycles; cfg_sdi is held stable.
  - chain_do is registered into config_do on the first SH_HI cycle.
  - On exit, shift left and increment the bit counter.
  - If 6 bits are done: col_cnt+1, go to IDLE, busy=0. Otherwise go to SH_LO.
- Shift latency: busy is high for exactly 12*HALF_PER cycles per word. cfg_sdi returns to 0 in IDLE.
- config_en dropped cases (word discarded, overrun=1):
  - config_en while busy.
  - config_en with col_cnt==NUM_DCOL.
- Commit (wr_en, index==111):
  - In IDLE with col_cnt==NUM_DCOL: go to LOAD.
  - While busy in SH_LO/SH_HI: set commit_pend; it is serviced on the cycle the block returns to IDLE.
  - Otherwise (col_cnt short, or in LOAD): ignored and overrun=1.
  - Once serviced, if col_cnt<NUM_DCOL the commit is discarded with overrun=1.
- LOAD: cfg_load=1 and busy=1 for LOAD_CYC cycles. Then IDLE, frame_done=1, col_cnt held.
- Same-cycle config_en and commit in IDLE: config_en is taken and the commit becomes commit_pend.
- Writes to any other index: ignored.
- col_cnt saturates at NUM_DCOL.
- rst asserted mid-shift or mid-load: next cycle, all outputs are at reset values. No partial pulse persists.

Optional Feature:
- Macro PIX_CFG_READBACK_EN.
- When defined:
  - All 6 chain_do samples of a word are accumulated into rb_word[5:0], MSB first.
  - Output rb_word is exposed, plus rb_valid, a one-cycle pulse on the IDLE-return cycle.
  - A write to index 110 with data_in[0]==1 clears rb_word.
- When undefined: rb_word and rb_valid are absent; config_do is the only readback.

Decomposition:
- Package pix_cfg_pkg holds:
  - the state enum (IDLE/SH_LO/SH_HI/LOAD);
  - register index constants IDX_FRAME=3'b000, IDX_CFG=3'b001, IDX_RB=3'b110, IDX_PUSH=3'b111;
  - CFG_BITS=6.
- One natural sub-module, pix_cfg_phase_timer: a down-counter that loads a value (HALF_PER or LOAD_CYC) and pulses expire. It is shared by the shift phases and LOAD.

Test Plan:
1. Shift one word. NUM_DCOL=4, HALF_PER=1; frame start, then config_en with data_in=8'h2D. Required: cfg_sdi sequence 1,0,1,1,0,1 with 6 cfg_sclk rising edges; busy high for 12 cycles; col_cnt=1.
2. Full frame and commit. Shift 4 words, then write index 111. Required: cfg_load high for 4 cycles; frame_done=1; overrun=0.
3. Overrun cases. A second config_en 3 cycles into a shift must be dropped with overrun=1 and the output word unchanged. A 5th config_en after col_cnt=4 must be dropped with overrun=1.
4. Deferred commit. Issue index 111 on the same cycle as the 4th config_en. Required: cfg_load starts on the cycle after shift completion (after 12 busy cycles), then frame_done=1.
5. Early commit. Write index 111 with col_cnt=2. Required: no cfg_load; overrun=1; a subsequent frame start clears overrun and col_cnt.
6. Reset mid-operation. Assert rst in SH_HI and in LOAD. Required: the next cycle has cfg_sclk=0, cfg_load=0, busy=0, col_cnt=0. With PIX_CFG_READBACK_EN and chain_do tied 1, rb_word=6'h3F after one word.
